rib_mem_resp: RTL and testbench

RIB_MEM_RESP -- requirements
Module: rib_mem_resp

---
 rtl/rib_mem_resp.sv | 138 +++++++++++++
 tb/tb_rib_mem_resp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rib_mem_resp.sv
// Word-addressed memory responder on the RIB bus with a fixed wait-state count.
// Define RIB_MEM_RESP_FAULT_LOG_EN to enable the sticky access-fault log.
module rib_mem_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        pmp_exception_i,
    input  logic        err_clr_i,
    output logic [31:0] data_o,
    output logic        hold_flag_o,
    output logic        err_valid_o,
    output logic [31:0] err_addr_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic [2:0]              cnt;
    logic [DEPTH_LOG2-1:0]   cap_idx;
    logic [31:0]             cap_data;
    logic                    cap_we;
    logic                    cap_fault;
    logic [31:0]             mem [DEPTH];

    logic                    hit;
    logic                    accept;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    enter_resp;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    rd_we;
    logic                    rd_fault;

    always_comb begin
        hit    = (addr_i[31:DEPTH_LOG2+2] == ADDR_BASE[31:DEPTH_LOG2+2]);
        idx    = addr_i[DEPTH_LOG2+1:2];
        accept = !rst && (state == S_IDLE) && req_i && hit;
        hold_flag_o = accept || (state == S_WAIT);
    end

    // With zero wait states RESP is entered straight from the accept cycle,
    // so the read source is the live request rather than the captured one.
    always_comb begin
        enter_resp = ((WAIT_CYCLES == 0) && accept) || ((state == S_WAIT) && (cnt == '0));
        rd_idx     = (state == S_IDLE) ? idx : cap_idx;
        rd_we      = (state == S_IDLE) ? we_i : cap_we;
        rd_fault   = (state == S_IDLE) ? pmp_exception_i : cap_fault;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_data  <= '0;
            cap_we    <= 1'b0;
            cap_fault <= 1'b0;
            data_o    <= '0;
        end else begin
            data_o <= '0;
            if (enter_resp && !rd_we && !rd_fault) begin
                data_o <= mem[rd_idx];
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_idx   <= idx;
                        cap_data  <= data_i;
                        cap_we    <= we_i;
                        cap_fault <= pmp_exception_i;
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                            cnt   <= 3'(WAIT_CYCLES - 1);
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; an async reset moves state out of RESP, which drops any pending write.
    always_ff @(posedge clk) begin
        if ((state == S_RESP) && cap_we && !cap_fault) begin
            mem[cap_idx] <= cap_data;
        end
    end

`ifdef RIB_MEM_RESP_FAULT_LOG_EN
    logic unused_bits;

    always_comb unused_bits = ^addr_i[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
        end else if (accept && pmp_exception_i && (!err_valid_o || err_clr_i)) begin
            err_valid_o <= 1'b1;
            err_addr_o  <= addr_i;
        end else if (err_clr_i) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
        end
    end
`else
    logic unused_bits;

    always_comb begin
        unused_bits = ^{addr_i[1:0], err_clr_i};
        err_valid_o = 1'b0;
        err_addr_o  = '0;
    end
`endif

endmodule

// File: tb/tb_rib_mem_resp.sv
// Directed bench for rib_mem_resp: one instance with one wait state, one with none.
module tb_rib_mem_resp;

`ifdef RIB_MEM_RESP_FAULT_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    localparam logic [31:0] A10 = 32'h1000_0010;
    localparam logic [31:0] A20 = 32'h1000_0020;
    localparam logic [31:0] A24 = 32'h1000_0024;
    localparam logic [31:0] A30 = 32'h1000_0030;
    localparam logic [31:0] ATOP = 32'h1000_0FFC;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst;

    logic        req1, we1, pmp1, clr1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata1, ea1;
    logic        hold1, ev1;

    logic        req0, we0, pmp0, clr0;
    logic [31:0] addr0, wdata0;
    logic [31:0] rdata0, ea0;
    logic        hold0, ev0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rib_mem_resp #(.ADDR_BASE(32'h1000_0000), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .data_i(wdata1),
        .pmp_exception_i(pmp1), .err_clr_i(clr1), .data_o(rdata1), .hold_flag_o(hold1),
        .err_valid_o(ev1), .err_addr_o(ea1)
    );

    rib_mem_resp #(.ADDR_BASE(32'h1000_0000), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .data_i(wdata0),
        .pmp_exception_i(pmp0), .err_clr_i(clr0), .data_o(rdata0), .hold_flag_o(hold0),
        .err_valid_o(ev0), .err_addr_o(ea0)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        pmp;
        logic        clr;
        logic        hold;
        logic [31:0] rdata;
        logic        ev;
        logic [31:0] ea;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                                input logic [31:0] data, input logic pmp, input logic clr,
                                input logic hold, input logic [31:0] rdata,
                                input logic ev, input logic [31:0] ea);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.data = data; v.pmp = pmp; v.clr = clr;
        v.hold = hold; v.rdata = rdata;
        // the log outputs are tied low when the feature is compiled out
        v.ev = LOG & ev;
        v.ea = LOG ? ea : 32'h0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step1(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        req1 = v.req; we1 = v.we; addr1 = v.addr; wdata1 = v.data; pmp1 = v.pmp; clr1 = v.clr;
        @(negedge clk);
        check({tag, " hold"}, {31'h0, hold1}, {31'h0, v.hold});
        check({tag, " data"}, rdata1, v.rdata);
        check({tag, " err_valid"}, {31'h0, ev1}, {31'h0, v.ev});
        check({tag, " err_addr"}, ea1, v.ea);
    endtask

    task automatic step0(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic exp_hold,
                         input logic [31:0] exp_data, input string tag);
        @(posedge clk);
        #1;
        req0 = req; we0 = we; addr0 = addr; wdata0 = data;
        @(negedge clk);
        check({tag, " hold"}, {31'h0, hold0}, {31'h0, exp_hold});
        check({tag, " data"}, rdata0, exp_data);
    endtask

    initial begin
        rst = 1'b1;
        {req1, we1, pmp1, clr1, req0, we0, pmp0, clr0} = '0;
        {addr1, wdata1, addr0, wdata0} = '0;

        // req rows: req we addr data pmp clr | hold rdata ev ea
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 1, A10,           DB,          0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 0, A10,           0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(1, 0, A10,           0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(1, 0, A10,           0,           0, 0, 0, DB, 0, 0));
        vecs.push_back(mk(1, 0, A10,           0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, DB, 0, 0));
        vecs.push_back(mk(1, 1, A20,           32'hAAA,     0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 1, A20,           32'h1234,    1, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  1, A20));
        vecs.push_back(mk(1, 0, A20,           0,           0, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 32'hAAA, 1, A20));
        vecs.push_back(mk(1, 1, A24,           32'h77,      1, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  1, A20));
        vecs.push_back(mk(1, 0, A20,           0,           1, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  1, A20));
        vecs.push_back(mk(1, 0, 32'h2000_0000, 0,           0, 0, 0, 0,  1, A20));
        vecs.push_back(mk(1, 0, 32'h2000_0000, 0,           0, 0, 0, 0,  1, A20));
        vecs.push_back(mk(1, 0, 32'h2000_0000, 0,           0, 0, 0, 0,  1, A20));
        vecs.push_back(mk(1, 0, 32'h1000_0013, 0,           0, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, DB, 1, A20));
        vecs.push_back(mk(1, 1, A30,           32'h5,       1, 1, 1, 0,  1, A20));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  1, A30));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  1, A30));
        vecs.push_back(mk(0, 0, 0,             0,           0, 1, 0, 0,  1, A30));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 0, 32'h1000_1000, 0,           0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 1, ATOP,          32'hCAFE,    0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 0, ATOP,          0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0,             0,           0, 0, 0, 32'hCAFE, 0, 0));

        @(negedge clk);
        check("rst hold1", {31'h0, hold1}, 32'h0);
        check("rst data1", rdata1, 32'h0);
        check("rst ev1", {31'h0, ev1}, 32'h0);
        check("rst ea1", ea1, 32'h0);
        check("rst hold0", {31'h0, hold0}, 32'h0);
        check("rst data0", rdata0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // zero-wait instance: write, then read with req held into and past RESP
        step0(1, 1, A10, DB, 1, 0,  "w0 wr C");
        step0(0, 0, 0,   0,  0, 0,  "w0 wr C+1");
        step0(1, 0, A10, 0,  1, 0,  "w0 rd C");
        step0(1, 0, A10, 0,  0, DB, "w0 rd C+1");
        step0(1, 0, A10, 0,  1, 0,  "w0 reacc C");
        step0(0, 0, 0,   0,  0, DB, "w0 reacc C+1");
        step0(0, 0, 0,   0,  0, 0,  "w0 idle");

        foreach (vecs[i]) begin
            step1(vecs[i], $sformatf("v%0d", i));
        end

        // reset mid-WAIT of a write: the write must never land
        @(posedge clk);
        #1;
        req1 = 1; we1 = 1; addr1 = A10; wdata1 = 32'h55; pmp1 = 0; clr1 = 0;
        @(negedge clk);
        check("rw accept hold", {31'h0, hold1}, 32'h1);
        @(posedge clk);
        #1;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        @(negedge clk);
        check("rw wait hold", {31'h0, hold1}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("rw rst hold", {31'h0, hold1}, 32'h0);
        check("rw rst data", rdata1, 32'h0);
        check("rw rst ev", {31'h0, ev1}, 32'h0);
        check("rw rst ea", ea1, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rw post hold", {31'h0, hold1}, 32'h0);
        step1(mk(1, 0, A10, 0, 0, 0, 1, 0,  0, 0), "rw rd C");
        step1(mk(0, 0, 0,   0, 0, 0, 1, 0,  0, 0), "rw rd C+1");
        step1(mk(0, 0, 0,   0, 0, 0, 0, DB, 0, 0), "rw rd C+2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
